// File: rtl/tart_nx_pkg.sv
// Shared types and constants for the TART-NX raw-capture packer.
package tart_nx_pkg;

  // Frame FSM: header bytes first, then sample bytes, then back to idle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_e;

  // Header: magic(2) + bytes-per-sample(1) + seq(2) + len(2).
  localparam int HDR_BYTES = 7;

  localparam logic [15:0] DEFAULT_MAGIC = 16'hA55A;

  // Bytes needed to carry one sample of `width` antenna bits.
  function automatic int nbytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/radio_sample_fifo.sv
// Synchronous sample FIFO with full/empty flags and a flush.
// The head entry is presented combinationally on rdata while not empty.
// A push on a full FIFO is accepted when a pop frees the slot in the same cycle.
module radio_sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_MAX);
  assign empty     = (count_r == '0);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r];

  // Sample storage; no reset needed, validity is tracked by count_r.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy, cleared by reset or flush.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/tart_nx_raw_packer.sv
// Raw-capture packer: buffers a burst of N-antenna sign-bit samples and
// emits one AXI4-Stream byte frame (7-byte header, then samples LSB byte
// first). Capture runs alongside header/data emission.
module tart_nx_raw_packer
  import tart_nx_pkg::*;
#(
  parameter int          WIDTH = 24,
  parameter int          DEPTH = 16,
  parameter logic [15:0] MAGIC = DEFAULT_MAGIC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [15:0]      length_i,
  input  logic             sig_tvalid_i,
  input  logic [WIDTH-1:0] sig_tdata_i,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [7:0]       m_tdata,
  output logic             busy_o,
  output logic             overflow_o
);

  localparam int             BYTES   = nbytes(WIDTH);
  localparam int             BI_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [7:0]     BYTES_B = 8'(BYTES);
  localparam logic [BI_W-1:0] LANE_LAST = BI_W'(BYTES - 1);
  localparam logic [BI_W-1:0] LANE_ONE  = BI_W'(1);
  localparam logic [2:0]     HDR_LAST = 3'(HDR_BYTES - 1);

  state_e            state_r;
  logic [15:0]       len_r;
  logic [15:0]       seq_r;
  logic [2:0]        hdr_cnt_r;
  logic [BI_W-1:0]   lane_r;
  logic [15:0]       out_cnt_r;
  logic [15:0]       cap_cnt_r;
  logic              busy_r;
  logic              overflow_r;
  logic              tvalid_r;
  logic              tlast_r;
  logic [7:0]        tdata_r;

  logic              accept_s;
  logic              slot_free_s;
  logic              last_hs_s;
  logic              capturing_s;
  logic              data_load_s;
  logic              lane_last_s;
  logic              sample_last_s;
  logic              fifo_push_s;
  logic              push_ok_s;
  logic              fifo_pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [WIDTH-1:0]  fifo_rdata_s;
  logic [BYTES*8-1:0] padded_s;
  logic [7:0]        lane_byte_s;
  logic [7:0]        hdr_byte_s;

  assign accept_s    = (state_r == IDLE) && start_i && (length_i != 16'd0);
  // Output register can take a new byte when empty or being consumed.
  assign slot_free_s = !tvalid_r || m_tready;
  assign last_hs_s   = tvalid_r && m_tready && tlast_r;
  assign capturing_s = (state_r != IDLE) && (cap_cnt_r != len_r);
  // Once the tlast byte is loaded nothing further is fetched this frame.
  assign data_load_s = (state_r == DATA) && slot_free_s && !tlast_r && !fifo_empty_s;
  assign lane_last_s   = (lane_r == LANE_LAST);
  assign sample_last_s = (out_cnt_r == (len_r - 16'd1));
  assign fifo_pop_s    = data_load_s && lane_last_s;
  assign fifo_push_s   = capturing_s && sig_tvalid_i;
  assign push_ok_s     = fifo_push_s && (!fifo_full_s || fifo_pop_s);

  radio_sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (accept_s),
    .push  (fifo_push_s),
    .wdata (sig_tdata_i),
    .pop   (fifo_pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Byte-lane mux: zero-extend the head sample and pick the current lane.
  assign padded_s    = (BYTES*8)'(fifo_rdata_s);
  assign lane_byte_s = padded_s[{lane_r, 3'b000} +: 8];

  // Header byte selection; byte 0 (MAGIC high) is loaded on start acceptance.
  always_comb begin
    hdr_byte_s = 8'd0;
    case (hdr_cnt_r)
      3'd1:    hdr_byte_s = MAGIC[7:0];
      3'd2:    hdr_byte_s = BYTES_B;
      3'd3:    hdr_byte_s = seq_r[15:8];
      3'd4:    hdr_byte_s = seq_r[7:0];
      3'd5:    hdr_byte_s = len_r[15:8];
      3'd6:    hdr_byte_s = len_r[7:0];
      default: hdr_byte_s = MAGIC[15:8];
    endcase
  end

  // Frame FSM, header/byte/sample counters and the registered AXI-S output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      len_r     <= 16'd0;
      seq_r     <= 16'd0;
      hdr_cnt_r <= 3'd0;
      lane_r    <= '0;
      out_cnt_r <= 16'd0;
      busy_r    <= 1'b0;
      tvalid_r  <= 1'b0;
      tlast_r   <= 1'b0;
      tdata_r   <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r   <= HEADER;
            len_r     <= length_i;
            busy_r    <= 1'b1;
            hdr_cnt_r <= 3'd1;
            lane_r    <= '0;
            out_cnt_r <= 16'd0;
            tvalid_r  <= 1'b1;
            tlast_r   <= 1'b0;
            tdata_r   <= MAGIC[15:8];
          end
        end
        HEADER: begin
          if (slot_free_s) begin
            tvalid_r  <= 1'b1;
            tlast_r   <= 1'b0;
            tdata_r   <= hdr_byte_s;
            hdr_cnt_r <= hdr_cnt_r + 3'd1;
            if (hdr_cnt_r == HDR_LAST) begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          if (last_hs_s) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            seq_r    <= seq_r + 16'd1;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
          end else if (data_load_s) begin
            tvalid_r <= 1'b1;
            tdata_r  <= lane_byte_s;
            tlast_r  <= lane_last_s && sample_last_s;
            if (lane_last_s) begin
              lane_r    <= '0;
              out_cnt_r <= out_cnt_r + 16'd1;
            end else begin
              lane_r <= lane_r + LANE_ONE;
            end
          end else if (slot_free_s) begin
            // FIFO ran dry: bubble until the next sample arrives.
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          tvalid_r <= 1'b0;
          tlast_r  <= 1'b0;
        end
      endcase
    end
  end

  // Capture counter and sticky drop flag; both restart with each accepted frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      cap_cnt_r  <= 16'd0;
      overflow_r <= 1'b0;
    end else if (accept_s) begin
      cap_cnt_r  <= 16'd0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        cap_cnt_r <= cap_cnt_r + 16'd1;
      end
      if (fifo_push_s && !push_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign m_tvalid   = tvalid_r;
  assign m_tlast    = tlast_r;
  assign m_tdata    = tdata_r;
  assign busy_o     = busy_r;
  assign overflow_o = overflow_r;

endmodule
